// File: rtl/wiphy_pkg.sv
// Shared Wi-Fi PHY types and helpers.
//   cplx_t       : complex sample, [15:0] I, [31:16] Q, signed Q1.15
//   prod_t       : full-precision complex product, 33-bit signed I and Q
//   PHASE_W      : phase word width; 2^PHASE_W is one full turn
//   ACC_W        : correlation accumulator width per component
//   conj_mult    : conj(a) * b at full precision
//   cordic_angle : atan(2^-idx) in full-turn phase units
package wiphy_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned PHASE_W  = 32;
    localparam int unsigned ACC_W    = 40;
    localparam int unsigned PROD_W   = 2 * SAMPLE_W + 1;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] q;
        logic signed [SAMPLE_W-1:0] i;
    } cplx_t;

    typedef struct packed {
        logic signed [PROD_W-1:0] q;
        logic signed [PROD_W-1:0] i;
    } prod_t;

    // conj(a) * b = (ai*bi + aq*bq) + j(ai*bq - aq*bi); each 16x16 product
    // fits in 32 bits, so a 33-bit sum is exact.
    function automatic prod_t conj_mult(cplx_t a, cplx_t b);
        prod_t                    p;
        logic signed [PROD_W-1:0] ai, aq, bi, bq;
        ai  = PROD_W'($signed(a.i));
        aq  = PROD_W'($signed(a.q));
        bi  = PROD_W'($signed(b.i));
        bq  = PROD_W'($signed(b.q));
        p.i = ai * bi + aq * bq;
        p.q = ai * bq - aq * bi;
        return p;
    endfunction

    function automatic logic [PHASE_W-1:0] cordic_angle(logic [4:0] idx);
        logic [PHASE_W-1:0] a;
        case (idx)
            5'd0:    a = 32'h2000_0000;
            5'd1:    a = 32'h12E4_051D;
            5'd2:    a = 32'h09FB_385B;
            5'd3:    a = 32'h0511_11D4;
            5'd4:    a = 32'h028B_0D43;
            5'd5:    a = 32'h0145_D7E1;
            5'd6:    a = 32'h00A2_F61E;
            5'd7:    a = 32'h0051_7C55;
            5'd8:    a = 32'h0028_BE53;
            5'd9:    a = 32'h0014_5F2E;
            5'd10:   a = 32'h000A_2F98;
            5'd11:   a = 32'h0005_17CC;
            5'd12:   a = 32'h0002_8BE6;
            5'd13:   a = 32'h0001_45F3;
            5'd14:   a = 32'h0000_A2F9;
            5'd15:   a = 32'h0000_517C;
            5'd16:   a = 32'h0000_28BE;
            5'd17:   a = 32'h0000_145F;
            5'd18:   a = 32'h0000_0A2F;
            5'd19:   a = 32'h0000_0517;
            5'd20:   a = 32'h0000_028B;
            5'd21:   a = 32'h0000_0145;
            5'd22:   a = 32'h0000_00A2;
            5'd23:   a = 32'h0000_0051;
            5'd24:   a = 32'h0000_0028;
            5'd25:   a = 32'h0000_0014;
            5'd26:   a = 32'h0000_000A;
            5'd27:   a = 32'h0000_0005;
            5'd28:   a = 32'h0000_0002;
            5'd29:   a = 32'h0000_0001;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/frequency_estimation_atan2.sv
// Iterative CORDIC vectoring atan2.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : accept x/y when both high (ready only while idle)
//   in_x, in_y          : 32-bit signed vector components
//   out_valid/out_ready : angle held until accepted
//   out_angle           : atan2(y, x), 2^32 = one full turn; 0 for a zero vector
// Latency: 31 cycles from input handshake to out_valid.
module frequency_estimation_atan2
    import wiphy_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [PHASE_W-1:0] in_x,
    input  logic signed [PHASE_W-1:0] in_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [PHASE_W-1:0] out_angle
);

    localparam int unsigned ITER  = 30;
    localparam int unsigned GUARD = 2;   // CORDIC gain plus negation headroom
    localparam int unsigned FRAC  = 4;   // extra LSBs so deep shifts keep precision
    localparam int unsigned IW    = GUARD + PHASE_W + FRAC;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic signed [IW-1:0] x_q, x_d, y_q, y_d;
    logic [PHASE_W-1:0]   z_q, z_d;
    logic [4:0]           iter_q, iter_d;
    logic                 zero_q, zero_d;
    logic signed [IW-1:0] x_ext, y_ext, x_sh, y_sh;

    always_comb begin
        x_ext   = {{GUARD{in_x[PHASE_W-1]}}, in_x, {FRAC{1'b0}}};
        y_ext   = {{GUARD{in_y[PHASE_W-1]}}, in_y, {FRAC{1'b0}}};
        x_sh    = x_q >>> iter_q;
        y_sh    = y_q >>> iter_q;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        iter_d  = iter_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    zero_d  = (in_x == '0) && (in_y == '0);
                    iter_d  = '0;
                    state_d = ST_RUN;
                    // Fold the left half-plane into the right by a quarter turn.
                    if (!in_x[PHASE_W-1]) begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = '0;
                    end else if (!in_y[PHASE_W-1]) begin
                        x_d = y_ext;
                        y_d = -x_ext;
                        z_d = 32'h4000_0000;
                    end else begin
                        x_d = -y_ext;
                        y_d = x_ext;
                        z_d = 32'hC000_0000;
                    end
                end
            end
            ST_RUN: begin
                // Rotate toward the x axis, accumulating the rotated angle.
                if (y_q[IW-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - cordic_angle(iter_q);
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + cordic_angle(iter_q);
                end
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'(ITER - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            iter_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            iter_q  <= iter_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_angle = zero_q ? '0 : z_q;

endmodule

// File: rtl/frequency_estimation.sv
// Coarse CFO estimator over the short training field.
// Correlates each sample against the one DELAY samples earlier, keeps a
// WINDOW-long moving sum, and on s_last converts the sum's angle into a
// per-sample phase increment. Samples pass through a single output register.
//   clk, reset            : clock, synchronous active-high reset
//   s_valid/s_ready       : input handshake
//   s_data, s_last        : complex sample; s_last requests an estimate
//   m_valid/m_ready       : output handshake
//   m_data                : s_data unchanged
//   m_user                : signed phase increment per sample, 2^32 = 2*pi
//   m_last                : m_user carries a fresh estimate on this beat
module frequency_estimation
    import wiphy_pkg::*;
#(
    parameter int unsigned DELAY  = 16,
    parameter int unsigned WINDOW = 48
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic [31:0]  m_user,
    output logic         m_last
);

    localparam int unsigned DLY_AW    = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int unsigned WIN_AW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned DLY_CW    = $clog2(DELAY + 1);
    localparam int unsigned WIN_CW    = $clog2(WINDOW + 1);
    localparam int unsigned LAG_SHIFT = $clog2(DELAY);
    localparam int unsigned ACC_SHIFT = 8;

    localparam logic [1:0] ST_STREAM   = 2'd0;
    localparam logic [1:0] ST_ESTIMATE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic [31:0] m_user_q, m_user_d;
    logic [31:0] m_data_q, m_data_d;
    logic        accept;

    // Delay line and product window: circular buffers with no reset so they
    // map onto RAM/SRL; fill counters mask unwritten entries to zero.
    cplx_t             dly_mem [DELAY];
    prod_t             win_mem [WINDOW];
    logic [DLY_AW-1:0] dly_ptr_q;
    logic [WIN_AW-1:0] win_ptr_q;
    logic [DLY_CW-1:0] dly_cnt_q;
    logic [WIN_CW-1:0] win_cnt_q;
    logic              dly_full, win_full;
    cplx_t             x_new, x_old;
    prod_t             p_new, p_old;

    logic signed [ACC_W-1:0]   acc_i_q, acc_q_q, acc_i_d, acc_q_d;
    logic                      atan_in_valid, atan_in_ready;
    logic                      atan_out_valid, atan_out_ready;
    logic        [PHASE_W-1:0] atan_angle;

    assign s_ready = (state_q == ST_STREAM) && (!m_valid_q || m_ready);
    assign accept  = s_valid && s_ready;

    assign x_new    = cplx_t'(s_data);
    assign dly_full = (dly_cnt_q == DLY_CW'(DELAY));
    assign win_full = (win_cnt_q == WIN_CW'(WINDOW));
    assign x_old    = dly_full ? dly_mem[dly_ptr_q] : '0;
    assign p_new    = conj_mult(x_old, x_new);
    assign p_old    = win_full ? win_mem[win_ptr_q] : '0;
    assign acc_i_d  = acc_i_q + ACC_W'($signed(p_new.i)) - ACC_W'($signed(p_old.i));
    assign acc_q_d  = acc_q_q + ACC_W'($signed(p_new.q)) - ACC_W'($signed(p_old.q));

    always_ff @(posedge clk) begin
        if (accept) begin
            dly_mem[dly_ptr_q] <= x_new;
            win_mem[win_ptr_q] <= p_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            dly_ptr_q <= '0;
            win_ptr_q <= '0;
            dly_cnt_q <= '0;
            win_cnt_q <= '0;
        end else if (accept) begin
            acc_i_q   <= acc_i_d;
            acc_q_q   <= acc_q_d;
            dly_ptr_q <= (dly_ptr_q == DLY_AW'(DELAY - 1)) ? '0 : dly_ptr_q + DLY_AW'(1);
            win_ptr_q <= (win_ptr_q == WIN_AW'(WINDOW - 1)) ? '0 : win_ptr_q + WIN_AW'(1);
            if (!dly_full) begin
                dly_cnt_q <= dly_cnt_q + DLY_CW'(1);
            end
            if (!win_full) begin
                win_cnt_q <= win_cnt_q + WIN_CW'(1);
            end
        end
    end

    // The estimate includes the s_last beat's own product, hence acc_*_d.
    assign atan_in_valid  = accept && s_last;
    assign atan_out_ready = (state_q == ST_ESTIMATE);

    frequency_estimation_atan2 u_atan2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (atan_in_valid),
        .in_ready  (atan_in_ready),
        .in_x      (acc_i_d[ACC_SHIFT +: PHASE_W]),
        .in_y      (acc_q_d[ACC_SHIFT +: PHASE_W]),
        .out_valid (atan_out_valid),
        .out_ready (atan_out_ready),
        .out_angle (atan_angle)
    );

    // The CORDIC is always idle in STREAM since ESTIMATE drains it.
    always_ff @(posedge clk) begin
        if (!reset && atan_in_valid) begin
            assert (atan_in_ready);
        end
    end

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;
        m_data_d  = m_data_q;
        case (state_q)
            ST_STREAM: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
                if (accept) begin
                    m_data_d = s_data;
                    m_last_d = 1'b0;
                    if (s_last) begin
                        // Sample parks in the output register until its estimate lands.
                        m_valid_d = 1'b0;
                        state_d   = ST_ESTIMATE;
                    end else begin
                        m_valid_d = 1'b1;
                    end
                end
            end
            ST_ESTIMATE: begin
                if (atan_out_valid) begin
                    // Angle spans DELAY samples; divide down to a per-sample step.
                    m_user_d  = 32'($signed(atan_angle) >>> LAG_SHIFT);
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    state_d   = ST_STREAM;
                end
            end
            default: state_d = ST_STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_STREAM;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_user_q  <= '0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_user  = m_user_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_frequency_estimation.sv
// Scoreboard bench for frequency_estimation: directed tones, DC, empty-memory
// estimate, random traffic with random backpressure, and reset mid-estimate.
module tb_frequency_estimation;

    localparam int DELAY  = 16;
    localparam int WINDOW = 48;
    localparam int TOL    = 16;
    localparam logic [31:0] NO_EST = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid, s_ready, s_last;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data, m_user;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] q_data[$];
    bit          q_last[$];
    int          q_user[$];
    logic [31:0] hist[$];
    int          cur_user       = 0;
    bit          rand_ready     = 1'b0;
    int          n_mlast        = 0;
    logic [31:0] last_user_seen = NO_EST;

    frequency_estimation #(
        .DELAY  (DELAY),
        .WINDOW (WINDOW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_user  (m_user),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    task automatic check_user(input string name, input logic [31:0] act, input int req);
        longint d;
        vectors++;
        d = longint'($signed(act)) - longint'(req);
        if (d > 64'sd134217728)  d = d - 64'sd268435456;
        if (d < -64'sd134217728) d = d + 64'sd268435456;
        if (d > TOL || d < -TOL) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (+/-%0d)", name, act, req, TOL);
        end
    endtask

    function automatic longint re(input logic [31:0] s);
        return longint'($signed(s[15:0]));
    endfunction

    function automatic longint im(input logic [31:0] s);
        return longint'($signed(s[31:16]));
    endfunction

    // Reference: direct sum of conj(x[k-DELAY])*x[k] over the last WINDOW
    // samples since reset, scaled by 2^-8, angle by real atan2.
    function automatic void model_accept(input logic [31:0] d, input bit l);
        longint ai, aq, n, lo;
        int     xs, ys;
        real    u;
        hist.push_back(d);
        if (l) begin
            ai = 0;
            aq = 0;
            n  = longint'(hist.size()) - 1;
            lo = (n - WINDOW + 1 > 0) ? n - WINDOW + 1 : 0;
            for (longint k = lo; k <= n; k++) begin
                if (k >= DELAY) begin
                    ai += re(hist[k-DELAY]) * re(hist[k]) + im(hist[k-DELAY]) * im(hist[k]);
                    aq += re(hist[k-DELAY]) * im(hist[k]) - im(hist[k-DELAY]) * re(hist[k]);
                end
            end
            xs = int'(ai >>> 8);
            ys = int'(aq >>> 8);
            if (xs == 0 && ys == 0) begin
                cur_user = 0;
            end else begin
                u = $atan2(real'(ys), real'(xs)) / (2.0 * 3.14159265358979) * 4294967296.0;
                cur_user = int'(u / real'(DELAY));
            end
        end
        q_data.push_back(d);
        q_last.push_back(l);
        q_user.push_back(cur_user);
    endfunction

    function automatic void model_reset();
        q_data.delete();
        q_last.delete();
        q_user.delete();
        hist.delete();
        cur_user = 0;
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic logic [31:0] tone(input int n, input int sgn);
        real  ph;
        int   i, q;
        logic [31:0] w;
        ph = 2.0 * 3.14159265358979 * real'(n) / 64.0;
        i  = rnd(8000.0 * $cos(ph));
        q  = rnd(real'(sgn) * 8000.0 * $sin(ph));
        w  = {q[15:0], i[15:0]};
        return w;
    endfunction

    // Entered and left at posedge+1.
    task automatic send(input logic [31:0] d, input bit l);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge clk);
        while (!s_ready) begin
            waited++;
            if (waited > 100) begin
                vectors++;
                miscompares++;
                $display("FAIL stall: s_ready low for %0d cycles, expected under 100", waited);
                @(posedge clk);
                #1;
                s_valid = 1'b0;
                s_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        model_accept(d, l);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (q_data.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        vectors++;
        if (q_data.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d beats outstanding, expected 0", q_data.size());
            model_reset();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset          = 1'b0;
        last_user_seen = NO_EST;
        n_mlast        = 0;
    endtask

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every output handshake pops one expected beat.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && m_valid && m_ready) begin
                if (q_data.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got data %08h, expected no output", m_data);
                end else begin
                    check("m_data", m_data, q_data.pop_front());
                    check("m_last", 32'(m_last), 32'(q_last.pop_front()));
                    check_user("m_user", m_user, q_user.pop_front());
                    if (m_last) begin
                        last_user_seen = m_user;
                        n_mlast++;
                    end
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_user", m_user, 32'd0);
        check("rst_m_data", m_data, 32'd0);
        @(posedge clk);
        #1;

        // Positive tone, quarter turn over the lag.
        for (int n = 0; n < 80; n++) send(tone(n, 1), n == 79);
        drain();
        check_user("tone_pos", last_user_seen, 32'h0400_0000);

        do_reset();
        for (int n = 0; n < 80; n++) send(tone(n, -1), n == 79);
        drain();
        check_user("tone_neg", last_user_seen, 32'hFC00_0000);

        do_reset();
        for (int n = 0; n < 200; n++) send(32'h0000_1F40, n == 63);
        drain();
        check_user("dc", last_user_seen, 0);
        check("dc_nlast", 32'(n_mlast), 32'd1);

        do_reset();
        send(32'h1234_5678, 1'b1);
        for (int n = 1; n < 4; n++) send($urandom, 1'b0);
        drain();
        check_user("empty_est", last_user_seen, 0);
        check("empty_nlast", 32'(n_mlast), 32'd1);

        do_reset();
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) send($urandom, (n % 160) == 159);
        drain();
        rand_ready = 1'b0;
        check("rand_nlast", 32'(n_mlast), 32'd6);

        // Reset while the CORDIC is busy: pending sample must vanish.
        do_reset();
        for (int n = 0; n < 80; n++) send(tone(n, 1), n == 79);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("rst_est_m_valid", 32'(m_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_est_s_ready", 32'(s_ready), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("rst_est_no_beat", last_user_seen, NO_EST);
        for (int n = 0; n < 80; n++) send(tone(n, 1), n == 79);
        drain();
        check_user("rst_est_fresh", last_user_seen, 32'h0400_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
